pcie_cq_cc_responder: RTL and testbench

//  PCIe completer-side endpoint for BAR0 register accesses. Consumes host requests on the CQ AXI-Stream
//  (64-bit, dword-aligned mode), applies MemWr to a local register file and answers MemRd with
//  CC completions. Sits between the PCIe core (user_clk domain) and the eth_top control registers.

---
 rtl/pcie_resp_pkg.sv | 68 ++++++
 rtl/pcie_resp_regfile.sv | 40 ++++
 rtl/pcie_cq_cc_responder.sv | 152 +++++++++++++++
 tb/tb_pcie_cq_cc_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_resp_pkg.sv
// Shared types and helpers for the BAR0 CQ/CC register responder.
package pcie_resp_pkg;

  typedef enum logic [3:0] {
    REQ_MEM_RD  = 4'b0000,
    REQ_MEM_WR  = 4'b0001,
    REQ_IO_RD   = 4'b0010,
    REQ_IO_WR   = 4'b0011,
    REQ_CFG_RD0 = 4'b1000,
    REQ_MSG     = 4'b1100
  } req_type_e;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001
  } cpl_status_e;

  typedef enum logic [2:0] {
    S_IDLE, S_DESC1, S_WDATA, S_DRAIN, S_CC0, S_CC1
  } state_e;

  typedef struct packed {
    logic [63:2] addr;
    logic [3:0]  first_be;
    logic [10:0] dword_cnt;
    logic [3:0]  req_type;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
  } cq_desc_t;

  typedef struct packed {
    logic [6:0]  lower_addr;
    logic [12:0] byte_count;
    logic [10:0] dword_count;
    logic [2:0]  status;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [2:0]  attr;
  } cc_desc_t;

  function automatic logic [12:0] byte_count(input logic [3:0] be);
    casez (be)
      4'b1??1:                   byte_count = 13'd4;
      4'b01?1, 4'b1?10:          byte_count = 13'd3;
      4'b0011, 4'b0110, 4'b1100: byte_count = 13'd2;
      default:                   byte_count = 13'd1;
    endcase
  endfunction

  function automatic logic [1:0] lo_addr(input logic [3:0] be);
    casez (be)
      4'b???1: lo_addr = 2'd0;
      4'b??10: lo_addr = 2'd1;
      4'b?100: lo_addr = 2'd2;
      4'b1000: lo_addr = 2'd3;
      default: lo_addr = 2'd0;
    endcase
  endfunction

  // Non-posted types: everything except MemWr and the message group (11xx).
  function automatic logic needs_cpl(input logic [3:0] t);
    needs_cpl = (t != REQ_MEM_WR) && (t[3:2] != 2'b11);
  endfunction

endpackage

// File: rtl/pcie_resp_regfile.sv
// NREGS x 32 register file: byte-enable write, combinational read, one-cycle write strobe.
module pcie_resp_regfile
  import pcie_resp_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_idx,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata,
  output logic [NREGS*32-1:0]   o_q,
  output logic [NREGS-1:0]      o_strb,
  output logic [31:0]           o_rdata
);

  logic [NREGS-1:0][31:0] r_regs;
  logic [NREGS-1:0]       r_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
      r_strb <= '0;
    end else begin
      r_strb <= '0;
      if (i_we) begin
        for (int b = 0; b < 4; b++)
          if (i_be[b]) r_regs[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        r_strb[i_idx] <= 1'b1;
      end
    end
  end

  assign o_q     = r_regs;
  assign o_strb  = r_strb;
  assign o_rdata = r_regs[i_idx];

endmodule

// File: rtl/pcie_cq_cc_responder.sv
// BAR0 completer: CQ MemWr/MemRd to a local register file, MemRd answered on CC.
// Define PCIE_CC_UR_EN to return UR completions for unsupported non-posted requests.
module pcie_cq_cc_responder
  import pcie_resp_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int NREGS        = 16
) (
  input  logic                      user_clk,
  input  logic                      sys_rst_n,
  input  logic [C_DATA_WIDTH-1:0]   m_axis_cq_tdata,
  input  logic [84:0]               m_axis_cq_tuser,
  input  logic                      m_axis_cq_tlast,
  input  logic [C_DATA_WIDTH/32-1:0] m_axis_cq_tkeep,
  input  logic                      m_axis_cq_tvalid,
  output logic                      m_axis_cq_tready,
  output logic [C_DATA_WIDTH-1:0]   s_axis_cc_tdata,
  output logic [32:0]               s_axis_cc_tuser,
  output logic                      s_axis_cc_tlast,
  output logic [C_DATA_WIDTH/32-1:0] s_axis_cc_tkeep,
  output logic                      s_axis_cc_tvalid,
  input  logic                      s_axis_cc_tready,
  output logic [NREGS*32-1:0]       reg_q,
  output logic [NREGS-1:0]          reg_wr_strb
);

  localparam int AW = $clog2(NREGS);

  state_e   r_state, w_next;
  cq_desc_t r_desc;
  cc_desc_t w_cc;
  logic     r_cq_tready, r_ur, w_ur, w_we;
  logic     w_xfer, w_sop, w_disc;
  logic [31:0] w_rdata, w_dw0, w_dw1, w_dw2;

  assign w_xfer = m_axis_cq_tvalid & r_cq_tready;
  assign w_sop  = m_axis_cq_tuser[40];
  assign w_disc = m_axis_cq_tuser[41];
  assign m_axis_cq_tready = r_cq_tready;

  always_comb begin
    w_next = r_state;
    w_ur   = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_xfer && w_sop && !m_axis_cq_tlast && !w_disc) w_next = S_DESC1;
      S_DESC1: if (w_xfer) begin
        if (w_disc)
          w_next = m_axis_cq_tlast ? S_IDLE : S_DRAIN;
        else if (m_axis_cq_tdata[14:11] == REQ_MEM_WR && m_axis_cq_tdata[10:0] == 11'd1)
          w_next = m_axis_cq_tlast ? S_IDLE : S_WDATA;
        else if (m_axis_cq_tdata[14:11] == REQ_MEM_RD) begin
          w_next = S_CC0;
          w_ur   = (m_axis_cq_tdata[10:0] != 11'd1);
        end
`ifdef PCIE_CC_UR_EN
        else if (needs_cpl(m_axis_cq_tdata[14:11])) begin
          w_next = S_CC0;
          w_ur   = 1'b1;
        end
`endif
        else
          w_next = m_axis_cq_tlast ? S_IDLE : S_DRAIN;
      end
      S_WDATA: if (w_xfer) begin
        w_we   = !w_disc;
        w_next = m_axis_cq_tlast ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: if (w_xfer && m_axis_cq_tlast) w_next = S_IDLE;
      S_CC0:   if (s_axis_cc_tready) w_next = S_CC1;
      S_CC1:   if (s_axis_cc_tready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_desc      <= '0;
      r_ur        <= 1'b0;
      r_cq_tready <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cq_tready <= (w_next != S_CC0) && (w_next != S_CC1);
      if (r_state == S_IDLE && w_xfer && w_sop) begin
        r_desc.addr     <= m_axis_cq_tdata[63:2];
        r_desc.first_be <= m_axis_cq_tuser[3:0];
      end
      if (r_state == S_DESC1 && w_xfer) begin
        r_desc.dword_cnt <= m_axis_cq_tdata[10:0];
        r_desc.req_type  <= m_axis_cq_tdata[14:11];
        r_desc.req_id    <= m_axis_cq_tdata[31:16];
        r_desc.tag       <= m_axis_cq_tdata[39:32];
        r_desc.tc        <= m_axis_cq_tdata[59:57];
        r_desc.attr      <= m_axis_cq_tdata[62:60];
        r_ur             <= w_ur;
      end
    end
  end

  pcie_resp_regfile #(.NREGS(NREGS), .AW(AW)) u_regs (
    .clk     (user_clk),
    .rst_n   (sys_rst_n),
    .i_we    (w_we),
    .i_idx   (r_desc.addr[AW+1:2]),
    .i_be    (r_desc.first_be),
    .i_wdata (m_axis_cq_tdata[31:0]),
    .o_q     (reg_q),
    .o_strb  (reg_wr_strb),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_cc.lower_addr  = {r_desc.addr[6:2], lo_addr(r_desc.first_be)};
    w_cc.byte_count  = r_ur ? 13'd4 : byte_count(r_desc.first_be);
    w_cc.dword_count = r_ur ? 11'd0 : 11'd1;
    w_cc.status      = r_ur ? CPL_UR : CPL_SC;
    w_cc.req_id      = r_desc.req_id;
    w_cc.tag         = r_desc.tag;
    w_cc.tc          = r_desc.tc;
    w_cc.attr        = r_desc.attr;
  end

  assign w_dw0 = {3'b0, w_cc.byte_count, 9'b0, w_cc.lower_addr};
  assign w_dw1 = {w_cc.req_id, 2'b0, w_cc.status, w_cc.dword_count};
  assign w_dw2 = {1'b0, w_cc.attr, w_cc.tc, 9'b0, 8'b0, w_cc.tag};

  // CC beats are driven straight from held state, so they stay stable under backpressure.
  always_comb begin
    s_axis_cc_tdata  = '0;
    s_axis_cc_tkeep  = '0;
    s_axis_cc_tlast  = 1'b0;
    s_axis_cc_tvalid = 1'b0;
    case (r_state)
      S_CC0: begin
        s_axis_cc_tdata  = {w_dw1, w_dw0};
        s_axis_cc_tkeep  = 2'b11;
        s_axis_cc_tvalid = 1'b1;
      end
      S_CC1: begin
        s_axis_cc_tdata  = {(r_ur ? 32'h0 : w_rdata), w_dw2};
        s_axis_cc_tkeep  = r_ur ? 2'b01 : 2'b11;
        s_axis_cc_tlast  = 1'b1;
        s_axis_cc_tvalid = 1'b1;
      end
      default: ;
    endcase
  end

  assign s_axis_cc_tuser = '0;

endmodule

// File: tb/tb_pcie_cq_cc_responder.sv
// Directed table-driven bench for pcie_cq_cc_responder plus stall/abort/reset sequences.
module tb_pcie_cq_cc_responder;

  localparam int NREGS = 16;

  logic              user_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [63:0]       cq_tdata = '0;
  logic [84:0]       cq_tuser = '0;
  logic              cq_tlast = 1'b0;
  logic [1:0]        cq_tkeep = '0;
  logic              cq_tvalid = 1'b0;
  logic              cq_tready;
  logic [63:0]       cc_tdata;
  logic [32:0]       cc_tuser;
  logic              cc_tlast;
  logic [1:0]        cc_tkeep;
  logic              cc_tvalid;
  logic              cc_tready = 1'b0;
  logic [NREGS*32-1:0] reg_q;
  logic [NREGS-1:0]  reg_wr_strb;

  pcie_cq_cc_responder #(.C_DATA_WIDTH(64), .NREGS(NREGS)) dut (
    .user_clk(user_clk), .sys_rst_n(sys_rst_n),
    .m_axis_cq_tdata(cq_tdata), .m_axis_cq_tuser(cq_tuser), .m_axis_cq_tlast(cq_tlast),
    .m_axis_cq_tkeep(cq_tkeep), .m_axis_cq_tvalid(cq_tvalid), .m_axis_cq_tready(cq_tready),
    .s_axis_cc_tdata(cc_tdata), .s_axis_cc_tuser(cc_tuser), .s_axis_cc_tlast(cc_tlast),
    .s_axis_cc_tkeep(cc_tkeep), .s_axis_cc_tvalid(cc_tvalid), .s_axis_cc_tready(cc_tready),
    .reg_q(reg_q), .reg_wr_strb(reg_wr_strb)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic        wr;
    logic [3:0]  rtype;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [10:0] cnt;
    logic [7:0]  tag;
    logic [15:0] rid;
    logic [2:0]  attr;
    logic [2:0]  tc;
    logic [31:0] wdata;
    logic        cc;
    logic [63:0] b0;
    logic [63:0] b1;
    logic [1:0]  k1;
    int          ridx;
    logic [31:0] rval;
    logic [15:0] strb;
  } vec_t;

  vec_t tv[11];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [3:0] rtype, input logic [31:0] addr,
      input logic [3:0] be, input logic [10:0] cnt, input logic [7:0] tag, input logic [15:0] rid,
      input logic [2:0] attr, input logic [2:0] tc, input logic [31:0] wdata, input logic cc,
      input logic [63:0] b0, input logic [63:0] b1, input logic [1:0] k1, input int ridx,
      input logic [31:0] rval, input logic [15:0] strb);
    vec_t v;
    v.wr = wr; v.rtype = rtype; v.addr = addr; v.be = be; v.cnt = cnt; v.tag = tag;
    v.rid = rid; v.attr = attr; v.tc = tc; v.wdata = wdata; v.cc = cc; v.b0 = b0;
    v.b1 = b1; v.k1 = k1; v.ridx = ridx; v.rval = rval; v.strb = strb;
    return v;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [84:0] u, input logic last,
                           input logic [1:0] keep);
    int t;
    @(negedge user_clk);
    cq_tdata = d; cq_tuser = u; cq_tlast = last; cq_tkeep = keep; cq_tvalid = 1'b1;
    t = 0;
    while (!cq_tready && t < 50) begin
      @(negedge user_clk);
      t++;
    end
    if (!cq_tready) check("cq_tready_timeout", 64'(cq_tready), 64'd1);
    @(posedge user_clk);
  endtask

  task automatic send_req(input vec_t v, input logic disc);
    logic [84:0] u;
    u = '0; u[3:0] = v.be; u[40] = 1'b1;
    send_beat({32'h0, v.addr}, u, 1'b0, 2'b11);
    u[40] = 1'b0;
    send_beat({1'b0, v.attr, v.tc, 17'h0, v.tag, v.rid, 1'b0, v.rtype, v.cnt}, u, !v.wr, 2'b11);
    if (v.wr) begin
      u[41] = disc;
      send_beat({32'h0, v.wdata}, u, 1'b1, 2'b01);
    end
  endtask

  // Called right after the edge that accepted the last request beat.
  task automatic get_cc(input string nm, input logic [63:0] b0, input logic [63:0] b1,
                        input logic [1:0] k1);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    check({nm, "_latency"}, 64'(cc_tvalid), 64'd1);
    check({nm, "_cq_rdy"}, 64'(cq_tready), 64'd0);
    check({nm, "_b0"}, cc_tdata, b0);
    check({nm, "_b0_kl"}, 64'({cc_tkeep, cc_tlast}), 64'({2'b11, 1'b0}));
    cc_tready = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    check({nm, "_b1"}, cc_tdata, b1);
    check({nm, "_b1_kl"}, 64'({cc_tkeep, cc_tlast}), 64'({k1, 1'b1}));
    @(posedge user_clk);
    @(negedge user_clk);
    cc_tready = 1'b0;
    check({nm, "_end"}, 64'(cc_tvalid), 64'd0);
  endtask

  task automatic no_cc(input string nm);
    logic seen;
    seen = 1'b0;
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen |= cc_tvalid;
      @(negedge user_clk);
    end
    check({nm, "_no_cc"}, 64'(seen), 64'd0);
    check({nm, "_cq_rdy"}, 64'(cq_tready), 64'd1);
  endtask

  initial begin
    vec_t sv;
    logic [84:0] u;
    logic cfg_cc;
`ifdef PCIE_CC_UR_EN
    cfg_cc = 1'b1;
`else
    cfg_cc = 1'b0;
`endif
    //           wr  type   addr   be   cnt tag    rid     at tc wdata    cc  beat0                  beat1                  k1  idx rval  strb
    tv[0]  = mk(1, 4'h1, 32'h0C, 4'hF, 1, 8'h00, 16'h0000, 0, 0, 32'hDEADBEEF, 0, 64'h0, 64'h0, 2'b00, 3, 32'hDEADBEEF, 16'h0008);
    tv[1]  = mk(0, 4'h0, 32'h0C, 4'hF, 1, 8'h2A, 16'h0100, 0, 0, 32'h0, 1, 64'h01000001_0004000C, 64'hDEADBEEF_0000002A, 2'b11, 0, 0, 0);
    tv[2]  = mk(1, 4'h1, 32'h0C, 4'h3, 1, 8'h00, 16'h0000, 0, 0, 32'h00001234, 0, 64'h0, 64'h0, 2'b00, 3, 32'hDEAD1234, 16'h0008);
    tv[3]  = mk(0, 4'h0, 32'h0C, 4'hF, 1, 8'h05, 16'h0100, 0, 0, 32'h0, 1, 64'h01000001_0004000C, 64'hDEAD1234_00000005, 2'b11, 0, 0, 0);
    tv[4]  = mk(0, 4'h0, 32'h14, 4'hF, 2, 8'h11, 16'h0200, 1, 2, 32'h0, 1, 64'h02000800_00040014, 64'h00000000_14000011, 2'b01, 0, 0, 0);
    tv[5]  = mk(0, 4'h8, 32'h00, 4'hF, 1, 8'h33, 16'h0300, 0, 0, 32'h0, cfg_cc, 64'h03000800_00040000, 64'h00000000_00000033, 2'b01, 0, 0, 0);
    tv[6]  = mk(0, 4'h0, 32'h10, 4'h2, 1, 8'h01, 16'h0400, 0, 0, 32'h0, 1, 64'h04000001_00010011, 64'h00000000_00000001, 2'b11, 0, 0, 0);
    tv[7]  = mk(1, 4'h1, 32'h4C, 4'hC, 1, 8'h00, 16'h0000, 0, 0, 32'hAB000000, 0, 64'h0, 64'h0, 2'b00, 3, 32'hAB001234, 16'h0008);
    tv[8]  = mk(0, 4'h0, 32'h4C, 4'h0, 1, 8'h07, 16'h0500, 0, 0, 32'h0, 1, 64'h05000001_0001004C, 64'hAB001234_00000007, 2'b11, 0, 0, 0);
    tv[9]  = mk(1, 4'h1, 32'h08, 4'h6, 1, 8'h00, 16'h0000, 0, 0, 32'h00CAFE00, 0, 64'h0, 64'h0, 2'b00, 2, 32'h00CAFE00, 16'h0004);
    tv[10] = mk(0, 4'h0, 32'h08, 4'h6, 1, 8'h40, 16'hFFFF, 0, 0, 32'h0, 1, 64'hFFFF0001_00020009, 64'h00CAFE00_00000040, 2'b11, 0, 0, 0);

    repeat (3) @(negedge user_clk);
    check("rst_cc_tvalid", 64'(cc_tvalid), 64'd0);
    check("rst_cq_tready", 64'(cq_tready), 64'd0);
    check("rst_cc_out", {cc_tdata[61:0], cc_tkeep}, 64'd0);
    check("rst_regq", 64'(reg_q == '0), 64'd1);
    check("rst_strb", 64'(reg_wr_strb), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge user_clk);
    check("post_rst_cq_tready", 64'(cq_tready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      send_req(tv[i], 1'b0);
      if (tv[i].wr) begin
        @(negedge user_clk);
        cq_tvalid = 1'b0;
        check($sformatf("v%0d_strb", i), 64'(reg_wr_strb), 64'(tv[i].strb));
        check($sformatf("v%0d_reg", i), 64'(reg_q[32*tv[i].ridx +: 32]), 64'(tv[i].rval));
        @(negedge user_clk);
        check($sformatf("v%0d_strb_off", i), 64'(reg_wr_strb), 64'd0);
      end else if (tv[i].cc)
        get_cc($sformatf("v%0d", i), tv[i].b0, tv[i].b1, tv[i].k1);
      else
        no_cc($sformatf("v%0d", i));
    end

    // Backpressure: 5 stalled cycles on each completion beat.
    sv = mk(0, 4'h0, 32'h0C, 4'hF, 1, 8'h2A, 16'h0100, 0, 0, 32'h0, 1, 0, 0, 2'b11, 0, 0, 0);
    send_req(sv, 1'b0);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_b0", cc_tdata, 64'h01000001_0004000C);
      check("stall_b0_vkl", 64'({cc_tvalid, cc_tkeep, cc_tlast}), 64'({1'b1, 2'b11, 1'b0}));
      check("stall_b0_cq_rdy", 64'(cq_tready), 64'd0);
      @(negedge user_clk);
    end
    cc_tready = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    cc_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_b1", cc_tdata, 64'hAB001234_0000002A);
      check("stall_b1_vkl", 64'({cc_tvalid, cc_tkeep, cc_tlast}), 64'({1'b1, 2'b11, 1'b1}));
      check("stall_b1_cq_rdy", 64'(cq_tready), 64'd0);
      @(negedge user_clk);
    end
    cc_tready = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    cc_tready = 1'b0;
    check("stall_end", 64'(cc_tvalid), 64'd0);

    // Discontinued write must not touch the register.
    sv = mk(1, 4'h1, 32'h08, 4'hF, 1, 8'h00, 16'h0000, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 2'b00, 2, 0, 0);
    send_req(sv, 1'b1);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    check("disc_strb", 64'(reg_wr_strb), 64'd0);
    check("disc_reg", 64'(reg_q[64 +: 32]), 64'h00CAFE00);

    // Stray non-sop beat in IDLE is dropped; following read is unaffected.
    u = '0; u[3:0] = 4'hF;
    send_beat(64'h0000_0000_0000_0401, u, 1'b0, 2'b11);
    send_req(tv[10], 1'b0);
    get_cc("nosop", tv[10].b0, tv[10].b1, tv[10].k1);

    // Reset in the middle of beat 1.
    send_req(tv[10], 1'b0);
    @(negedge user_clk);
    cq_tvalid = 1'b0;
    cc_tready = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    cc_tready = 1'b0;
    check("midrst_in_cc1", 64'({cc_tvalid, cc_tlast}), 64'({1'b1, 1'b1}));
    sys_rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 64'(cc_tvalid), 64'd0);
    check("midrst_cc_out", {cc_tdata[61:0], cc_tkeep}, 64'd0);
    check("midrst_tlast", 64'(cc_tlast), 64'd0);
    check("midrst_regq", 64'(reg_q == '0), 64'd1);
    check("midrst_cq_rdy", 64'(cq_tready), 64'd0);
    repeat (2) @(negedge user_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge user_clk);
    check("postrst_idle_rdy", 64'(cq_tready), 64'd1);
    check("postrst_tvalid", 64'(cc_tvalid), 64'd0);
    sv = mk(0, 4'h0, 32'h0C, 4'hF, 1, 8'h2A, 16'h0100, 0, 0, 32'h0, 1, 0, 0, 2'b11, 0, 0, 0);
    send_req(sv, 1'b0);
    get_cc("postrst_rd", 64'h01000001_0004000C, 64'h00000000_0000002A, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
